// File: rtl/bus_initiator_pkg.sv
// Shared bus definitions: transaction state encoding, default read timeout and widths.
package bus_initiator_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4
    } bus_state_t;

    localparam int BUS_TIMEOUT_DEFAULT = 15;
    localparam int BUS_ADDR_W          = 32;
    localparam int BUS_DATA_W          = 16;

    // Counter width able to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bus_initiator_tri_state.sv
// Tri-state driver primitive for a shared bidirectional bus.
module bus_initiator_tri_state #(
    parameter int W = 16
) (
    input  logic         en,
    input  logic [W-1:0] d,
    inout  wire  [W-1:0] pad
);

    assign pad = en ? d : {W{1'bz}};

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: turns req/rsp handshakes into write and
// read cycles on a multiplexed strobe bus, with a bounded wait for read completion.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | ready for a request; bus strobes low, data released
// WR      | one cycle: address + write data driven, writeEn/addressDataEn high
// RD_ADDR | one cycle: address phase of a read, data released
// RD_WAIT | outputEn high, waiting for readDone or the timeout count
// RESP    | response held on rsp_* until rsp_ready
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [BUS_ADDR_W-1:0] req_addr,
    input  logic [BUS_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BUS_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [BUS_ADDR_W-1:0] address,
    inout  wire  [BUS_DATA_W-1:0] data,
    output logic                  addressDataEn,
    output logic                  writeEn,
    output logic                  outputEn,
    input  logic                  readDone
);

    localparam int               CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    bus_state_t            state;
    bus_state_t            state_next;
    logic [CNT_W-1:0]      wait_cnt;
    logic [BUS_DATA_W-1:0] wdata_q;
    logic                  drive_en;
    logic                  accept;
    logic                  done_seen;
    logic                  timed_out;
    logic                  rd_finish;
    logic                  write_en_next;
    logic                  ade_next;
    logic                  oe_next;
    logic                  drive_next;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    // A floating or unknown readDone must never end the wait.
    assign done_seen = (readDone === 1'b1);
    assign timed_out = (wait_cnt == CNT_MAX);
    assign rd_finish = (state == RD_WAIT) && (done_seen || timed_out);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_write ? WR : RD_ADDR;
            WR:      state_next = RESP;
            RD_ADDR: state_next = RD_WAIT;
            RD_WAIT: if (done_seen || timed_out) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered, so they line up with the state.
    always_comb begin
        write_en_next = (state_next == WR);
        ade_next      = (state_next == WR) || (state_next == RD_ADDR);
        oe_next       = (state_next == RD_WAIT);
        drive_next    = (state_next == WR);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            writeEn       <= 1'b0;
            addressDataEn <= 1'b0;
            outputEn      <= 1'b0;
            drive_en      <= 1'b0;
            address       <= '0;
            wdata_q       <= '0;
            wait_cnt      <= '0;
            rsp_rdata     <= '0;
            rsp_error     <= 1'b0;
        end else begin
            writeEn       <= write_en_next;
            addressDataEn <= ade_next;
            outputEn      <= oe_next;
            drive_en      <= drive_next;

            if (accept) begin
                address <= req_addr;
                wdata_q <= req_wdata;
            end

            if (state == RD_ADDR) begin
                wait_cnt <= '0;
            end else if ((state == RD_WAIT) && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // Writes leave rsp_rdata untouched so it keeps the last read value.
            if (state == WR) begin
                rsp_error <= 1'b0;
            end else if (rd_finish) begin
                rsp_rdata <= data;
                rsp_error <= !done_seen;
            end
        end
    end

    bus_initiator_tri_state #(
        .W (BUS_DATA_W)
    ) u_data_drv (
        .en  (drive_en),
        .d   (wdata_q),
        .pad (data)
    );

endmodule
